data_ram_arbiter: RTL and testbench
===================================

# data_ram_arbiter

Sequencing arbiter that shares the single-port data RAM between two requesters: port A (processor load/store stage) and port B (I/O / DMA engine). It accepts one request at a time over a req/ack handshake and drives the RAM's write data, address and write enable. It returns read data and an out-of-range error flag to the winning requester. It sits between the memory stage and the data RAM; the RAM's write clock and read clock are both tied to `clock`.

## Interface
- `ADDR_WIDTH`, 10: RAM address width.
- `DATA_WIDTH`, 32: RAM word width.
- `RAM_DEPTH`, 301: number of implemented words; valid addresses are 0..RAM_DEPTH-1.

- `clock`  in  1  single system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `a_req`  in  1  port A request; held with fields stable until `a_ack`.
- `a_we`  in  1  port A write (1) / read (0).
- `a_addr`  in  ADDR_WIDTH  port A word address.
- `a_wdata`  in  DATA_WIDTH  port A write data.
- `a_ack`  out  1  one-cycle completion pulse.
- `a_rdata`  out  DATA_WIDTH  read data; valid only while `a_ack`=1.
- `a_err`  out  1  address out of range; valid while `a_ack`=1.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`, `b_err`: same definitions for port B.
- `ram_dataC`  out  DATA_WIDTH  RAM write data.
- `ram_address`  out  ADDR_WIDTH  RAM address.
- `ram_writeEnable`  out  1  RAM write enable.
- `ram_dataRAMOutput`  in  DATA_WIDTH  RAM registered read data.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: if any `req` is high, pick the winner and latch its we/addr/wdata. Latch a range flag (addr >= RAM_DEPTH). Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive `ram_address` = latched addr and `ram_dataC` = latched wdata. Drive `ram_writeEnable` = latched we AND NOT range flag. The RAM writes on the negedge inside this cycle and registers read data at the following posedge. Go to CAPTURE.
- CAPTURE: pulse the winner's `ack`.
  - For an in-range read, `rdata` = `ram_dataRAMOutput`.
  - For a write or an error, `rdata` = 0.
  - `err` = range flag.
  - Go to IDLE.
- Out-of-range request: no RAM write occurs, `err`=1, and latency is unchanged.
- Fields are sampled only at grant; requester changes after grant are ignored.
- A `req` still high in the cycle after its `ack` counts as a new request.
- Simultaneous `a_req` and `b_req` in IDLE are resolved per Configuration. The loser keeps waiting and is not acknowledged.
- `ram_writeEnable` is registered and high only in ISSUE. `ram_address` and `ram_dataC` hold their last value outside ISSUE.

## Timing
- Grant to ack latency: request seen in IDLE at edge N; ISSUE during N..N+1; `ack` high during N+2..N+3. This gives 3 cycles per transaction and a throughput of 1 access per 3 cycles.
- Reset values: state IDLE, all `ack`/`err` 0, all `rdata` 0, `ram_writeEnable` 0, `ram_address` 0, `ram_dataC` 0, round-robin pointer "B last".
- Reset asserted during ISSUE: the in-flight negedge write still completes, because enable is already registered. At the next posedge, state becomes IDLE and no `ack` is issued. The requester must re-request.
- Reset asserted during CAPTURE: the `ack` already driven in that cycle stands, and outputs clear at the next posedge.

## Configuration
- `DATA_RAM_ARB_RR_EN` defined: round-robin. On a tie, grant the port not granted last. The pointer updates on every grant, and the first tie after reset goes to A.
- Undefined: fixed priority, A always wins ties, and B may starve. The pointer register is not built.

## Structure
- Package `data_ram_pkg`:
  - state enum (IDLE, ISSUE, CAPTURE);
  - `ADDR_WIDTH`, `DATA_WIDTH`, `RAM_DEPTH` defaults;
  - port-select encoding (PORT_A=0, PORT_B=1).
- One sub-module, `data_ram_arb_pick`, is natural. It is combinational winner selection from `a_req`, `b_req` and the pointer, and holds all `DATA_RAM_ARB_RR_EN` conditional logic.

## Test plan
- A writes 0xDEADBEEF to addr 5, then reads addr 5: RAM write enable high for exactly one cycle. The read `a_ack` arrives 3 cycles after grant with `a_rdata`=0xDEADBEEF and `a_err`=0.
- B reads addr 300 after writing 0x12345678 there → `b_rdata`=0x12345678. B writes addr 301 → `b_err`=1, `ram_writeEnable` never high, and a subsequent read of addr 300 still returns 0x12345678.
- A and B request together continuously for 6 transactions:
  - with RR, acks alternate A,B,A,B,A,B;
  - without RR, all 6 go to A and B receives no `ack`.
- A request arrives while a B transaction is in ISSUE: A waits, then is granted in the IDLE cycle after B's ack. B changing `b_addr` after grant does not alter the accessed address.
- Reset pulsed low during ISSUE of a write of 0xA5A5A5A5 to addr 7: the write lands in RAM, no `ack` is produced, and outputs match reset values one cycle later.
- Read of a never-written but in-range addr immediately after reset: `ack` arrives with `err`=0, and `rdata` equals the RAM content (bench checks the model's value).

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared types and sizing for the data RAM arbiter: FSM states, port select, RAM geometry.
// addr_oor flags word addresses beyond the implemented RAM depth.
package data_ram_pkg;

   localparam int unsigned ADDR_WIDTH = 10;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned RAM_DEPTH  = 301;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_t;

   function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
      return 32'(addr) >= RAM_DEPTH;
   endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// One requester port of the data RAM arbiter: req/ack handshake with write fields and read response.
// master = requester (memory stage or DMA engine), slave = arbiter.
interface data_ram_arbiter_if;
   import data_ram_pkg::*;

   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  err;

   modport master (output req, we, addr, wdata, input ack, rdata, err);
   modport slave  (input req, we, addr, wdata, output ack, rdata, err);

endinterface

// File: rtl/data_ram_arb_pick.sv
// Combinational winner selection between port A and port B; zero latency.
// DATA_RAM_ARB_RR_EN selects round-robin on ties, otherwise A has fixed priority.
module data_ram_arb_pick
   import data_ram_pkg::*;
(
   input  logic      a_req,
   input  logic      b_req,
   input  port_sel_t last,
   output logic      grant,
   output port_sel_t sel
);

   assign grant = a_req | b_req;

`ifdef DATA_RAM_ARB_RR_EN
   // On a tie the port that did not win last time goes next.
   always_comb begin
      sel = PORT_A;
      if (b_req && (!a_req || last == PORT_A)) begin
         sel = PORT_B;
      end
   end
`else
   logic unused_last;
   assign unused_last = (last == PORT_B);

   always_comb begin
      sel = PORT_A;
      if (b_req && !a_req) begin
         sel = PORT_B;
      end
   end
`endif

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between ports A and B; one access per 3 cycles, ack 2 edges after grant.
// Losing requester simply waits with req held; optional DATA_RAM_ARB_RR_EN gives round-robin ties.
module data_ram_arbiter
   import data_ram_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   data_ram_arbiter_if.slave     a,
   data_ram_arbiter_if.slave     b,
   output logic [DATA_WIDTH-1:0] ram_dataC,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_writeEnable,
   input  logic [DATA_WIDTH-1:0] ram_dataRAMOutput
);

   state_t                state, state_nxt;
   port_sel_t             sel, sel_nxt, pick_sel;
   logic                  grant;
   logic                  we_q, we_nxt, oor_q, oor_nxt, wen_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt, rd_val;
   logic                  a_ack_nxt, b_ack_nxt, a_err_nxt, b_err_nxt;
   logic [DATA_WIDTH-1:0] a_rdata_nxt, b_rdata_nxt;

   // The latched winner doubles as the "last granted" pointer.
   data_ram_arb_pick u_pick (
      .a_req (a.req),
      .b_req (b.req),
      .last  (sel),
      .grant (grant),
      .sel   (pick_sel)
   );

   assign rd_val = (we_q || oor_q) ? '0 : ram_dataRAMOutput;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state           <= IDLE;
         sel             <= PORT_B;
         we_q            <= 1'b0;
         oor_q           <= 1'b0;
         ram_address     <= '0;
         ram_dataC       <= '0;
         ram_writeEnable <= 1'b0;
         a.ack           <= 1'b0;
         a.err           <= 1'b0;
         a.rdata         <= '0;
         b.ack           <= 1'b0;
         b.err           <= 1'b0;
         b.rdata         <= '0;
      end else begin
         state           <= state_nxt;
         sel             <= sel_nxt;
         we_q            <= we_nxt;
         oor_q           <= oor_nxt;
         ram_address     <= addr_nxt;
         ram_dataC       <= wdata_nxt;
         ram_writeEnable <= wen_nxt;
         a.ack           <= a_ack_nxt;
         a.err           <= a_err_nxt;
         a.rdata         <= a_rdata_nxt;
         b.ack           <= b_ack_nxt;
         b.err           <= b_err_nxt;
         b.rdata         <= b_rdata_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      sel_nxt     = sel;
      we_nxt      = we_q;
      oor_nxt     = oor_q;
      addr_nxt    = ram_address;
      wdata_nxt   = ram_dataC;
      wen_nxt     = 1'b0;
      a_ack_nxt   = 1'b0;
      b_ack_nxt   = 1'b0;
      a_err_nxt   = 1'b0;
      b_err_nxt   = 1'b0;
      a_rdata_nxt = '0;
      b_rdata_nxt = '0;
      case (state)
         IDLE: begin
            if (grant) begin
               sel_nxt = pick_sel;
               if (pick_sel == PORT_B) begin
                  we_nxt    = b.we;
                  addr_nxt  = b.addr;
                  wdata_nxt = b.wdata;
               end else begin
                  we_nxt    = a.we;
                  addr_nxt  = a.addr;
                  wdata_nxt = a.wdata;
               end
               oor_nxt   = addr_oor(addr_nxt);
               wen_nxt   = we_nxt && !oor_nxt;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = CAPTURE;
         CAPTURE: begin
            // RAM read data registered at the end of ISSUE is stable here.
            if (sel == PORT_A) begin
               a_ack_nxt   = 1'b1;
               a_err_nxt   = oor_q;
               a_rdata_nxt = rd_val;
            end else begin
               b_ack_nxt   = 1'b1;
               b_err_nxt   = oor_q;
               b_rdata_nxt = rd_val;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (grant timestamps, expected RAM contents).
module tb_data_ram_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ram_dataC;
   logic [9:0]  ram_address;
   logic        ram_writeEnable;
   logic [31:0] ram_dataRAMOutput = '0;

   data_ram_arbiter_if a_if ();
   data_ram_arbiter_if b_if ();

   data_ram_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .a                 (a_if),
      .b                 (b_if),
      .ram_dataC         (ram_dataC),
      .ram_address       (ram_address),
      .ram_writeEnable   (ram_writeEnable),
      .ram_dataRAMOutput (ram_dataRAMOutput)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int we_cnt = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // RAM: write on negedge, registered read on posedge.
   logic [31:0] mem [0:1023];
   always @(negedge clock) if (ram_writeEnable) mem[ram_address] <= ram_dataC;
   always @(posedge clock) ram_dataRAMOutput <= mem[ram_address];
   always @(negedge clock) if (ram_writeEnable === 1'b1) we_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: a grant happens when a request is present and 3 cycles have passed
   // since the previous grant; the response appears 2 edges after the grant.
   logic [31:0] model_mem [0:1023];
   int          mcyc = 0, free_at = 0, ack_at = 0;
   bit          started = 0, pend = 0, pend_port = 0, pend_err = 0, last_b = 1;
   logic [31:0] pend_rd = '0, exp_rd = '0;
   bit          exp_a_ack = 0, exp_b_ack = 0, exp_we = 0, exp_err = 0;

   always @(posedge clock) begin
      bit          win, w, oor;
      logic [9:0]  ad;
      logic [31:0] wd;
      mcyc++;
      exp_a_ack = 0;
      exp_b_ack = 0;
      exp_we    = 0;
      if (!reset) begin
         pend    = 0;
         free_at = 0;
         last_b  = 1;
      end else begin
         if (pend && mcyc == ack_at) begin
            if (pend_port) exp_b_ack = 1; else exp_a_ack = 1;
            exp_rd  = pend_rd;
            exp_err = pend_err;
            pend    = 0;
         end
         if (mcyc >= free_at && (a_if.req || b_if.req)) begin
`ifdef DATA_RAM_ARB_RR_EN
            win = (a_if.req && b_if.req) ? !last_b : b_if.req;
`else
            win = b_if.req && !a_if.req;
`endif
            w  = win ? b_if.we    : a_if.we;
            ad = win ? b_if.addr  : a_if.addr;
            wd = win ? b_if.wdata : a_if.wdata;
            oor = (int'(ad) >= 301);
            pend_rd  = (w || oor) ? 32'h0 : model_mem[ad];
            if (w && !oor) model_mem[ad] = wd;
            exp_we    = w && !oor;
            pend      = 1;
            pend_port = win;
            pend_err  = oor;
            ack_at    = mcyc + 2;
            free_at   = mcyc + 3;
            last_b    = win;
         end
      end
      started = 1;
   end

   always @(negedge clock) begin
      if (started) begin
         chk("a_ack", {31'b0, a_if.ack}, {31'b0, exp_a_ack});
         chk("b_ack", {31'b0, b_if.ack}, {31'b0, exp_b_ack});
         chk("ram_we", {31'b0, ram_writeEnable}, {31'b0, exp_we});
         if (exp_a_ack) begin
            chk("a_rdata", a_if.rdata, exp_rd);
            chk("a_err", {31'b0, a_if.err}, {31'b0, exp_err});
         end
         if (exp_b_ack) begin
            chk("b_rdata", b_if.rdata, exp_rd);
            chk("b_err", {31'b0, b_if.err}, {31'b0, exp_err});
         end
      end
   end

   task automatic drive(input bit port, input bit r, input bit w, input logic [9:0] ad, input logic [31:0] wd);
      if (port) begin
         b_if.req = r; b_if.we = w; b_if.addr = ad; b_if.wdata = wd;
      end else begin
         a_if.req = r; a_if.we = w; a_if.addr = ad; a_if.wdata = wd;
      end
   endtask

   task automatic set_req(input bit port, input bit r);
      if (port) b_if.req = r; else a_if.req = r;
   endtask

   task automatic wait_ack(input bit port, output logic [31:0] rd, output logic er);
      int n = 0;
      while (n < 40) begin
         @(negedge clock);
         if ((port ? b_if.ack : a_if.ack) === 1'b1) break;
         n++;
      end
      if (n == 40) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout: port %0d got no ack within 40 cycles", port);
      end
      rd = port ? b_if.rdata : a_if.rdata;
      er = port ? b_if.err : a_if.err;
   endtask

   task automatic txn(input bit port, input bit w, input logic [9:0] ad, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
      int c0;
      @(posedge clock); #1;
      drive(port, 1'b1, w, ad, wd);
      c0 = cyc;
      wait_ack(port, rd, er);
      lat = cyc - c0;
      set_req(port, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ram_address"}, {22'b0, ram_address}, 32'h0);
      chk({tag, "_ram_dataC"}, ram_dataC, 32'h0);
      chk({tag, "_ram_we"}, {31'b0, ram_writeEnable}, 32'h0);
      chk({tag, "_a_ack"}, {31'b0, a_if.ack}, 32'h0);
      chk({tag, "_b_ack"}, {31'b0, b_if.ack}, 32'h0);
      chk({tag, "_a_rdata"}, a_if.rdata, 32'h0);
      chk({tag, "_b_err"}, {31'b0, b_if.err}, 32'h0);
   endtask

   task automatic requester(input bit port, input int n);
      logic [31:0] rd;
      logic        er;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clock);
         @(posedge clock); #1;
         drive(port, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 310)), $urandom);
         wait_ack(port, rd, er);
         set_req(port, 1'b0);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, w0, t_b, nack;
      logic [5:0]  seq, exp_seq;

      for (int i = 0; i < 1024; i++) begin
         mem[i]       = {16'hC0DE, 16'(i)};
         model_mem[i] = {16'hC0DE, 16'(i)};
      end
      drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);

      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("rst0");
      reset = 1'b1;

      // Never-written in-range read straight after reset.
      txn(1'b1, 1'b0, 10'd100, 32'h0, rd, er, lat);
      chk("fresh_rdata", rd, 32'hC0DE0064);
      chk("fresh_err", {31'b0, er}, 32'h0);

      // A write then read of addr 5.
      w0 = we_cnt;
      txn(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, rd, er, lat);
      chk("a_write_we_cycles", 32'(we_cnt - w0), 32'd1);
      txn(1'b0, 1'b0, 10'd5, 32'h0, rd, er, lat);
      chk("a_read_rdata", rd, 32'hDEADBEEF);
      chk("a_read_err", {31'b0, er}, 32'h0);
      chk("a_read_latency", 32'(lat), 32'd3);

      // B at the top of the range, then one past it.
      txn(1'b1, 1'b1, 10'd300, 32'h12345678, rd, er, lat);
      txn(1'b1, 1'b0, 10'd300, 32'h0, rd, er, lat);
      chk("b_read300", rd, 32'h12345678);
      w0 = we_cnt;
      txn(1'b1, 1'b1, 10'd301, 32'hFFFF0000, rd, er, lat);
      chk("b_oor_err", {31'b0, er}, 32'h1);
      chk("b_oor_rdata", rd, 32'h0);
      chk("b_oor_latency", 32'(lat), 32'd3);
      chk("b_oor_we_cycles", 32'(we_cnt - w0), 32'd0);
      txn(1'b1, 1'b0, 10'd300, 32'h0, rd, er, lat);
      chk("b_read300_after_oor", rd, 32'h12345678);

      // B granted alone; its fields change after grant and A arrives during ISSUE.
      @(posedge clock); #1;
      drive(1'b1, 1'b1, 1'b1, 10'd20, 32'h0BADF00D);
      @(posedge clock); #1;
      b_if.addr  = 10'd21;
      b_if.wdata = 32'hFFFFFFFF;
      drive(1'b0, 1'b1, 1'b0, 10'd20, 32'h0);
      wait_ack(1'b1, rd, er);
      set_req(1'b1, 1'b0);
      t_b = cyc;
      wait_ack(1'b0, rd, er);
      set_req(1'b0, 1'b0);
      chk("a_after_b_gap", 32'(cyc - t_b), 32'd3);
      chk("a_reads_b_write", rd, 32'h0BADF00D);
      txn(1'b0, 1'b0, 10'd21, 32'h0, rd, er, lat);
      chk("addr21_untouched", rd, 32'hC0DE0015);

      // Reset during ISSUE of a write: the write lands, no ack.
      @(posedge clock); #1;
      drive(1'b0, 1'b1, 1'b1, 10'd7, 32'hA5A5A5A5);
      @(posedge clock); #1;
      reset = 1'b0;
      set_req(1'b0, 1'b0);
      @(posedge clock); #1;
      reset = 1'b1;
      check_reset_outputs("rst_issue");
      repeat (4) @(negedge clock);
      chk("ram7_written", mem[7], 32'hA5A5A5A5);
      txn(1'b0, 1'b0, 10'd7, 32'h0, rd, er, lat);
      chk("a_read7", rd, 32'hA5A5A5A5);

      // Continuous tie between A and B right after a reset.
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 10'd1, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 10'd2, 32'h0);
      nack = 0;
      seq  = '0;
      for (int c = 0; c < 40 && nack < 6; c++) begin
         @(negedge clock);
         if (a_if.ack === 1'b1) begin seq[nack] = 1'b0; nack++; end
         if (b_if.ack === 1'b1) begin seq[nack] = 1'b1; nack++; end
      end
      set_req(1'b0, 1'b0);
      set_req(1'b1, 1'b0);
`ifdef DATA_RAM_ARB_RR_EN
      exp_seq = 6'b101010;
`else
      exp_seq = 6'b000000;
`endif
      chk("tie_ack_count", 32'(nack), 32'd6);
      chk("tie_ack_order", {26'b0, seq}, {26'b0, exp_seq});
      repeat (3) @(posedge clock);

      // Random concurrent traffic, including out-of-range addresses.
      fork
         requester(1'b0, 40);
         requester(1'b1, 40);
      join
      repeat (4) @(posedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
